// File: rtl/prog_timer_bus_pkg.sv
// Shared constants for the programmable timer CPU front end: the register map,
// the CTRL bit positions and the clock-selection codes.
package prog_timer_pkg;

  localparam logic [11:0] ADDR_DATA_LO   = 12'hF24;
  localparam logic [11:0] ADDR_DATA_HI   = 12'hF25;
  localparam logic [11:0] ADDR_RELOAD_LO = 12'hF26;
  localparam logic [11:0] ADDR_RELOAD_HI = 12'hF27;
  localparam logic [11:0] ADDR_CTRL      = 12'hF78;
  localparam logic [11:0] ADDR_CLKSEL    = 12'hF79;
  localparam logic [11:0] ADDR_FACTOR    = 12'hF02;
  localparam logic [11:0] ADDR_MASK      = 12'hF12;

  localparam int CTRL_RUN_BIT = 0;
  localparam int CTRL_RST_BIT = 1;

  // Codes 000 and 001 both select the K03 source.
  typedef enum logic [2:0] {
    CLK_K03     = 3'b000,
    CLK_K03_ALT = 3'b001,
    CLK_256HZ   = 3'b010,
    CLK_512HZ   = 3'b011,
    CLK_1024HZ  = 3'b100,
    CLK_2048HZ  = 3'b101,
    CLK_4096HZ  = 3'b110,
    CLK_8192HZ  = 3'b111
  } clk_sel_e;

endpackage

// File: rtl/prog_timer_bus_if.sv
// Nibble-wide CPU bus between the MMIO decoder (master) and a peripheral (slave).
interface prog_timer_bus_if;
  logic [11:0] bus_addr;
  logic [3:0]  bus_wdata;
  logic        bus_write;
  logic        bus_read;
  logic [3:0]  bus_rdata;
  logic        bus_rdata_valid;

  modport master (
    output bus_addr, bus_wdata, bus_write, bus_read,
    input  bus_rdata, bus_rdata_valid
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_write, bus_read,
    output bus_rdata, bus_rdata_valid
  );
endinterface

// File: rtl/prog_timer_bus.sv
// CPU register front end for the programmable timer: decodes nibble accesses
// into timer controls, returns counter/flag state and produces the masked irq.
module prog_timer_bus
  import prog_timer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  prog_timer_bus_if.slave      bus,
  input  logic [7:0]           timer_downcounter,
  input  logic                 timer_factor_flag,
  output logic                 timer_enable,
  output logic                 timer_reset,
  output logic [2:0]           timer_clock_sel,
  output logic [7:0]           timer_reload,
  output logic                 timer_reset_factor,
  output logic                 irq
);

  logic [3:0] r_rdata;
  logic       r_rdata_valid;
  logic       r_enable;
  logic       r_reset;
  clk_sel_e   r_clk_sel;
  logic [7:0] r_reload;
  logic       r_reset_factor;
  logic       r_mask;
  logic       r_irq;
  logic [3:0] r_shadow;
  logic       r_shadow_valid;

  logic [3:0] w_rdata;

  always_comb begin
    w_rdata = 4'h0;
    case (bus.bus_addr)
      ADDR_DATA_LO:   w_rdata = timer_downcounter[3:0];
      ADDR_DATA_HI:   w_rdata = r_shadow_valid ? r_shadow : timer_downcounter[7:4];
      ADDR_RELOAD_LO: w_rdata = r_reload[3:0];
      ADDR_RELOAD_HI: w_rdata = r_reload[7:4];
      ADDR_CTRL:      w_rdata = {3'b000, r_enable};
      ADDR_CLKSEL:    w_rdata = {1'b0, r_clk_sel};
      ADDR_FACTOR:    w_rdata = {3'b000, timer_factor_flag};
      ADDR_MASK:      w_rdata = {3'b000, r_mask};
      default:        w_rdata = 4'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rdata        <= 4'h0;
      r_rdata_valid  <= 1'b0;
      r_enable       <= 1'b0;
      r_reset        <= 1'b0;
      r_clk_sel      <= CLK_K03;
      r_reload       <= 8'h00;
      r_reset_factor <= 1'b0;
      r_mask         <= 1'b0;
      r_irq          <= 1'b0;
      r_shadow       <= 4'h0;
      r_shadow_valid <= 1'b0;
    end else begin
      r_rdata_valid  <= 1'b0;
      r_reset        <= 1'b0;
      r_reset_factor <= 1'b0;
      r_irq          <= timer_factor_flag & r_mask;
      // A write wins over a simultaneous read; the read is silently dropped.
      if (bus.bus_write) begin
        r_shadow_valid <= 1'b0;
        case (bus.bus_addr)
          ADDR_RELOAD_LO: r_reload[3:0] <= bus.bus_wdata;
          ADDR_RELOAD_HI: r_reload[7:4] <= bus.bus_wdata;
          ADDR_CTRL: begin
            r_enable <= bus.bus_wdata[CTRL_RUN_BIT];
            r_reset  <= bus.bus_wdata[CTRL_RST_BIT];
          end
          ADDR_CLKSEL:    r_clk_sel <= clk_sel_e'(bus.bus_wdata[2:0]);
          ADDR_MASK:      r_mask    <= bus.bus_wdata[0];
          default:        ;
        endcase
      end else if (bus.bus_read) begin
        r_rdata       <= w_rdata;
        r_rdata_valid <= 1'b1;
        case (bus.bus_addr)
          ADDR_DATA_LO: begin
            r_shadow       <= timer_downcounter[7:4];
            r_shadow_valid <= 1'b1;
          end
          ADDR_DATA_HI: r_shadow_valid <= 1'b0;
          ADDR_FACTOR:  r_reset_factor <= timer_factor_flag;
          default:      ;
        endcase
      end
    end
  end

  assign bus.bus_rdata       = r_rdata;
  assign bus.bus_rdata_valid = r_rdata_valid;
  assign timer_enable        = r_enable;
  assign timer_reset         = r_reset;
  assign timer_clock_sel     = r_clk_sel;
  assign timer_reload        = r_reload;
  assign timer_reset_factor  = r_reset_factor;
  assign irq                 = r_irq;

endmodule

// File: tb/tb_prog_timer_bus.sv
// Self-checking bench for prog_timer_bus: read data is scoreboarded through a
// queue filled when each read is issued and drained when valid pulses.
module tb_prog_timer_bus;
  import prog_timer_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [7:0] timer_downcounter;
  logic       timer_factor_flag;
  logic       timer_enable;
  logic       timer_reset;
  logic [2:0] timer_clock_sel;
  logic [7:0] timer_reload;
  logic       timer_reset_factor;
  logic       irq;

  prog_timer_bus_if bus_if ();

  prog_timer_bus dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .bus                (bus_if),
    .timer_downcounter  (timer_downcounter),
    .timer_factor_flag  (timer_factor_flag),
    .timer_enable       (timer_enable),
    .timer_reset        (timer_reset),
    .timer_clock_sel    (timer_clock_sel),
    .timer_reload       (timer_reload),
    .timer_reset_factor (timer_reset_factor),
    .irq                (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_v;

  // Every valid pulse must match the oldest outstanding expected read.
  always @(negedge clk) begin
    if (bus_if.bus_rdata_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: rdata=%h with no read outstanding", bus_if.bus_rdata);
      end else begin
        exp_v = exp_q.pop_front();
        if (bus_if.bus_rdata !== exp_v) begin
          n_fail++;
          $display("FAIL rdata: got %h expected %h", bus_if.bus_rdata, exp_v);
        end
      end
    end
  end

  task automatic do_read(input logic [11:0] addr, input logic [3:0] exp);
    @(negedge clk);
    bus_if.bus_addr = addr;
    bus_if.bus_read = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    bus_if.bus_read = 1'b0;
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [3:0] data);
    @(negedge clk);
    bus_if.bus_addr  = addr;
    bus_if.bus_wdata = data;
    bus_if.bus_write = 1'b1;
    @(negedge clk);
    bus_if.bus_write = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    n_checks++;
    if ({timer_enable, timer_reset, timer_clock_sel, timer_reload, timer_reset_factor, irq} !== 15'h0) begin
      n_fail++;
      $display("FAIL %s_outputs: en=%b rst=%b sel=%h reload=%h rf=%b irq=%b expected all 0",
               tag, timer_enable, timer_reset, timer_clock_sel, timer_reload, timer_reset_factor, irq);
    end
  endtask

  task automatic test_reset();
    logic [11:0] addrs[9];
    addrs = '{ADDR_DATA_LO, ADDR_DATA_HI, ADDR_RELOAD_LO, ADDR_RELOAD_HI,
              ADDR_CTRL, ADDR_CLKSEL, ADDR_FACTOR, ADDR_MASK, 12'h123};
    check_outputs_zero("reset");
    n_checks++;
    if (bus_if.bus_rdata !== 4'h0 || bus_if.bus_rdata_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bus: rdata=%h valid=%b expected 0 0", bus_if.bus_rdata, bus_if.bus_rdata_valid);
    end
    foreach (addrs[i]) do_read(addrs[i], 4'h0);
  endtask

  task automatic test_reload_ctrl();
    do_write(ADDR_RELOAD_LO, 4'h5);
    do_write(ADDR_RELOAD_HI, 4'hA);
    n_checks++;
    if (timer_reload !== 8'hA5) begin
      n_fail++;
      $display("FAIL reload: got %h expected a5", timer_reload);
    end
    do_read(ADDR_RELOAD_HI, 4'hA);
    do_read(ADDR_RELOAD_LO, 4'h5);
    // CTRL write: pulse visible one cycle, then gone.
    @(negedge clk);
    bus_if.bus_addr  = ADDR_CTRL;
    bus_if.bus_wdata = 4'b0011;
    bus_if.bus_write = 1'b1;
    @(negedge clk);
    bus_if.bus_write = 1'b0;
    n_checks++;
    if (timer_enable !== 1'b1 || timer_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL ctrl_write: en=%b rst=%b expected 1 1", timer_enable, timer_reset);
    end
    @(negedge clk);
    n_checks++;
    if (timer_reset !== 1'b0 || timer_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL ctrl_pulse_width: en=%b rst=%b expected 1 0", timer_enable, timer_reset);
    end
    do_read(ADDR_CTRL, 4'h1);
  endtask

  task automatic test_shadow();
    timer_downcounter = 8'h3C;
    do_read(ADDR_DATA_LO, 4'hC);
    timer_downcounter = 8'h2B;
    do_read(ADDR_DATA_HI, 4'h3);
    do_read(ADDR_DATA_HI, 4'h2);
    timer_downcounter = 8'h7E;
    do_read(ADDR_DATA_LO, 4'hE);
    timer_downcounter = 8'h91;
    do_write(ADDR_DATA_LO, 4'hF);
    do_read(ADDR_DATA_HI, 4'h9);
  endtask

  task automatic test_irq_factor();
    timer_factor_flag = 1'b1;
    do_write(ADDR_MASK, 4'h1);
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_set: got %b expected 1", irq);
    end
    do_read(ADDR_MASK, 4'h1);
    n_checks++;
    if (timer_reset_factor !== 1'b0) begin
      n_fail++;
      $display("FAIL factor_idle: got %b expected 0", timer_reset_factor);
    end
    do_read(ADDR_FACTOR, 4'h1);
    n_checks++;
    if (timer_reset_factor !== 1'b1) begin
      n_fail++;
      $display("FAIL factor_pulse: got %b expected 1", timer_reset_factor);
    end
    @(negedge clk);
    n_checks++;
    if (timer_reset_factor !== 1'b0) begin
      n_fail++;
      $display("FAIL factor_pulse_width: got %b expected 0", timer_reset_factor);
    end
    timer_factor_flag = 1'b0;
    do_read(ADDR_FACTOR, 4'h0);
    n_checks++;
    if (timer_reset_factor !== 1'b0) begin
      n_fail++;
      $display("FAIL factor_no_pulse: got %b expected 0", timer_reset_factor);
    end
    timer_factor_flag = 1'b1;
    do_write(ADDR_MASK, 4'h0);
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_masked: got %b expected 0", irq);
    end
    do_write(ADDR_MASK, 4'h1);
  endtask

  task automatic test_collision_and_reset();
    @(negedge clk);
    bus_if.bus_addr  = ADDR_CLKSEL;
    bus_if.bus_wdata = 4'h6;
    bus_if.bus_write = 1'b1;
    bus_if.bus_read  = 1'b1;
    @(negedge clk);
    bus_if.bus_write = 1'b0;
    bus_if.bus_read  = 1'b0;
    n_checks++;
    if (timer_clock_sel !== 3'b110 || bus_if.bus_rdata_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL collision: sel=%b valid=%b expected 110 0", timer_clock_sel, bus_if.bus_rdata_valid);
    end
    do_read(ADDR_CLKSEL, 4'h6);
    // Reset arrives together with a read (plus a pending RST write pulse).
    do_write(ADDR_CTRL, 4'b0011);
    @(negedge clk);
    bus_if.bus_addr = ADDR_RELOAD_HI;
    bus_if.bus_read = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    bus_if.bus_read = 1'b0;
    reset_n = 1'b1;
    check_outputs_zero("midreset");
    n_checks++;
    if (bus_if.bus_rdata_valid !== 1'b0 || bus_if.bus_rdata !== 4'h0) begin
      n_fail++;
      $display("FAIL midreset_bus: valid=%b rdata=%h expected 0 0", bus_if.bus_rdata_valid, bus_if.bus_rdata);
    end
    @(negedge clk);
    check_outputs_zero("postreset");
    timer_factor_flag = 1'b0;
    do_read(ADDR_MASK, 4'h0);
    do_read(ADDR_RELOAD_HI, 4'h0);
  endtask

  initial begin
    reset_n           = 1'b0;
    timer_downcounter = 8'h00;
    timer_factor_flag = 1'b0;
    bus_if.bus_addr   = 12'h000;
    bus_if.bus_wdata  = 4'h0;
    bus_if.bus_write  = 1'b0;
    bus_if.bus_read   = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    test_reset();
    test_reload_ctrl();
    test_shadow();
    test_irq_factor();
    test_collision_and_reset();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d reads outstanding expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_timer_bus.md
Name: prog_timer_bus

Overview:
- CPU-facing register front end for the programmable timer.
- Decodes 4-bit nibble reads/writes from the core's data bus into the timer's control inputs: run enable, reset pulse, clock selection, 8-bit reload, factor clear.
- Returns the timer's downcounter and factor flag to the CPU.
- Gates the factor flag with an interrupt mask to produce the timer's interrupt request.
- Sits between the CPU memory-mapped I/O decoder and the timer block.

Parameters:
- ADDR_DATA_LO, 12'hF24, downcounter bits [3:0], read-only
- ADDR_DATA_HI, 12'hF25, downcounter bits [7:4], read-only
- ADDR_RELOAD_LO, 12'hF26, reload bits [3:0], read/write
- ADDR_RELOAD_HI, 12'hF27, reload bits [7:4], read/write
- ADDR_CTRL, 12'hF78, bit0 RUN (r/w); bit1 RST (write-1 pulse, reads 0)
- ADDR_CLKSEL, 12'hF79, bits [2:0] clock selection; bit3 reads 0
- ADDR_FACTOR, 12'hF02, bit0 factor flag; read-to-clear
- ADDR_MASK, 12'hF12, bit0 interrupt enable mask, read/write

Ports:
- clk, in, 1, system clock
- reset_n, in, 1, reset (synchronous, active-low); clock clk
- bus_addr, in, 12, CPU nibble address
- bus_wdata, in, 4, write data
- bus_write, in, 1, write strobe, one cycle per access
- bus_read, in, 1, read strobe, one cycle per access
- bus_rdata, out, 4, read data
- bus_rdata_valid, out, 1, one-cycle pulse accompanying bus_rdata
- timer_downcounter, in, 8, live downcounter from the timer
- timer_factor_flag, in, 1, factor flag from the timer
- timer_enable, out, 1, RUN bit
- timer_reset, out, 1, one-cycle reload pulse
- timer_clock_sel, out, 3, clock selection
- timer_reload, out, 8, reload value
- timer_reset_factor, out, 1, one-cycle factor-clear pulse
- irq, out, 1, registered timer interrupt request (factor AND mask)

Behaviour:
Reset:
- While reset_n=0 at a clk edge, all state clears: bus_rdata=0, bus_rdata_valid=0, timer_enable=0, timer_reset=0, timer_clock_sel=0, timer_reload=0, timer_reset_factor=0, mask=0, irq=0, shadow invalid.
- Reset mid-access aborts the access. No pulse is emitted the following cycle.

Writes (take effect on the clk edge where bus_write=1):
- RELOAD_LO/HI update only their nibble of timer_reload.
- CTRL: timer_enable<=wdata[0]. If wdata[1]=1, timer_reset=1 for exactly the next cycle. RUN and RST in the same write both apply.
- CLKSEL: timer_clock_sel<=wdata[2:0].
- MASK: mask<=wdata[0].
- Writes to DATA_LO/HI and FACTOR are ignored.
- Any write invalidates the shadow.

Reads:
- Latency 1: bus_rdata and bus_rdata_valid are registered in the cycle after bus_read.
- Unused bits and unmapped addresses return 0. An unmapped read still pulses valid.
- DATA_LO returns downcounter[3:0] and captures downcounter[7:4] into the shadow, marking it valid.
- DATA_HI returns the shadow if valid, otherwise the live [7:4]. Either way the shadow is then invalidated. This gives a coherent 8-bit read for LO-then-HI.
- CTRL returns {2'b0, 1'b0, RUN}. CLKSEL returns {1'b0, sel}. RELOAD returns the stored nibble. MASK returns {3'b0, mask}.
- FACTOR returns {3'b0, timer_factor_flag} sampled in the read cycle. If the sampled value is 1, timer_reset_factor=1 for exactly the next cycle. If it is 0, no pulse.

Simultaneous events:
- bus_read and bus_write in the same cycle: the write executes, the read is dropped (no valid pulse).
- A timer set coinciding with the clear pulse is lost, because the timer gives clear priority. This matches silicon read-clear behaviour.

irq:
- irq<=timer_factor_flag & mask, every cycle.
- Mask=0 forces irq=0 on the next edge, with no effect on the flag.

Decomposition:
- Package prog_timer_pkg holds:
  - default address localparams;
  - CTRL bit indices (RUN=0, RST=1);
  - clock-selection encodings (K03=3'b000/001, 256Hz=3'b010 … 8192Hz=3'b111).
- No sub-module is natural: a single module with one register decode always-block plus the irq register.

Test Plan:
- Reset then read each register -> rdata=0 on every address; irq=0; all timer outputs 0.
- Write RELOAD_LO=4'h5, RELOAD_HI=4'hA -> timer_reload=8'hA5. Write CTRL=4'b0011 -> timer_enable=1 and timer_reset high exactly one cycle.
- timer_downcounter=8'h3C, read DATA_LO, change downcounter to 8'h2B, read DATA_HI -> rdata 4'hC then 4'h3. A second HI read returns the live value 4'h2.
- Hold timer_factor_flag=1, mask=1 -> irq=1. Read FACTOR -> rdata=4'h1 and timer_reset_factor pulses once. With flag=0, read FACTOR -> rdata=0 and no pulse.
- Same-cycle bus_read and bus_write to CLKSEL with wdata=4'h6 -> timer_clock_sel=3'b110 and no rdata_valid. Then assert reset_n=0 mid-read -> no valid pulse; all outputs are back at reset values.
